// File: rtl/tbdec_timers.sv
`default_nettype none
// ============================================================================
// Module   : tbdec_timers
// Purpose  : Prescaled timebase plus DEC_CHANNELS decrementers with optional
//            auto-reload and sticky expiry-pending flags.
// Revision : 1.0 - initial release
// ============================================================================
module tbdec_timers #(
  parameter int TB_WIDTH     = 64,
  parameter int DEC_CHANNELS = 2,
  parameter int DEC_WIDTH    = 32,
  parameter int PRESCALE_L2  = 1
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              write_en,
  input  logic [4:0]                        write_sel,
  input  logic [31:0]                       write_val,
  input  logic [DEC_CHANNELS-1:0]           autoreload,
  input  logic [DEC_CHANNELS-1:0]           dec_ack,
  output logic [TB_WIDTH-1:0]               tb,
  output logic [DEC_CHANNELS*DEC_WIDTH-1:0] dec,
  output logic [DEC_CHANNELS-1:0]           dec_msb,
  output logic [DEC_CHANNELS-1:0]           dec_pending
);

  logic        w_tick;
  logic        w_wr_tbl;
  logic [31:0] r_tbl;

  // Shared tick: asserted in the cycle the free-running prescaler is all-ones.
  if (PRESCALE_L2 == 0) begin : g_presc_none
    assign w_tick = 1'b1;
  end else begin : g_presc
    logic [PRESCALE_L2-1:0] r_presc;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_presc <= '0;
      else          r_presc <= r_presc + PRESCALE_L2'(1);
    end
    assign w_tick = &r_presc;
  end

  assign w_wr_tbl = write_en && (write_sel == 5'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_tbl <= '0;
    else if (w_wr_tbl) r_tbl <= write_val;
    else if (w_tick)   r_tbl <= r_tbl + 32'd1;
  end

  if (TB_WIDTH == 64) begin : g_tbu
    logic [31:0] r_tbu;
    logic        w_wr_tbu;
    logic        w_carry;
    assign w_wr_tbu = write_en && (write_sel == 5'd1);
    // Carry looks at the registered TBL, so a same-cycle TBL write cannot hide it.
    assign w_carry  = w_tick && (r_tbl == 32'hffff_ffff);
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)      r_tbu <= '0;
      else if (w_wr_tbu) r_tbu <= write_val;
      else if (w_carry)  r_tbu <= r_tbu + 32'd1;
    end
    assign tb = {r_tbu, r_tbl};
  end else begin : g_tb32
    assign tb = r_tbl;
  end

  for (genvar c = 0; c < DEC_CHANNELS; c++) begin : g_chan
    localparam logic [4:0] C_SEL_DEC   = 5'(2 + 2*c);
    localparam logic [4:0] C_SEL_DECAR = 5'(3 + 2*c);

    logic [DEC_WIDTH-1:0] r_dec;
    logic [DEC_WIDTH-1:0] r_decar;
    logic                 r_msb;
    logic                 r_pend;
    logic                 w_wr_dec;
    logic                 w_wr_decar;
    logic                 w_expire;

    assign w_wr_dec   = write_en && (write_sel == C_SEL_DEC);
    assign w_wr_decar = write_en && (write_sel == C_SEL_DECAR);
    // A write to DEC swallows that cycle's tick, including any expiry.
    assign w_expire   = w_tick && !w_wr_dec && (r_dec == '0);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)        r_decar <= '0;
      else if (w_wr_decar) r_decar <= write_val[DEC_WIDTH-1:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_dec <= '1;
      end else if (w_wr_dec) begin
        r_dec <= write_val[DEC_WIDTH-1:0];
      end else if (w_tick) begin
        if (r_dec != '0)        r_dec <= r_dec - DEC_WIDTH'(1);
        else if (autoreload[c]) r_dec <= r_decar;
        else                    r_dec <= '1;
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        r_pend <= 1'b0;
        r_msb  <= 1'b1;
      end else begin
        r_msb <= r_dec[DEC_WIDTH-1];
        if (w_expire)        r_pend <= 1'b1;
        else if (dec_ack[c]) r_pend <= 1'b0;
      end
    end

    assign dec[c*DEC_WIDTH +: DEC_WIDTH] = r_dec;
    assign dec_msb[c]                    = r_msb;
    assign dec_pending[c]                = r_pend;
  end

endmodule
`default_nettype wire
